// File: rtl/zet_sram_bridge.sv
// zet_sram_bridge: CPU strobe/ack slave driving a 16-bit async SRAM with wait states,
// splitting unaligned word accesses into two SRAM cycles.
module zet_sram_bridge #(
  parameter int WAIT = 1,
  parameter int AW   = 19
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [AW:0]   adr_i,
  input  logic [15:0]   dat_i,
  output logic [15:0]   dat_o,
  input  logic          we_i,
  input  logic          mio_i,
  input  logic          byte_i,
  input  logic          stb_i,
  output logic          ack_o,
  output logic [AW-1:0] sram_a_o,
  input  logic [15:0]   sram_dq_i,
  output logic [15:0]   sram_dq_o,
  output logic          sram_dq_oe_o,
  output logic          sram_ce_n_o,
  output logic          sram_oe_n_o,
  output logic          sram_we_n_o,
  output logic          sram_ub_n_o,
  output logic          sram_lb_n_o
);
  typedef enum logic [1:0] {IDLE, ACC1, ACC2, ACK} state_t;
  localparam logic [2:0] LAST = 3'(WAIT);
  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [AW:0]   adr_q, adr_d;
  logic [15:0]   dat_q, dat_d, rdat_q, rdat_d, dq_q, dq_d;
  logic [7:0]    lo_q, lo_d;
  logic [AW-1:0] a_q, a_d;
  logic          we_q, we_d, byte_q, byte_d, split_q, split_d, ack_q, ack_d, dq_oe_q, dq_oe_d;
  logic          ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d, ub_n_q, ub_n_d, lb_n_q, lb_n_d;
  logic          last, acc, sec, whole;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    we_d    = we_q;
    byte_d  = byte_q;
    split_d = split_q;
    lo_d    = lo_q;
    rdat_d  = rdat_q;
    last    = cnt_q == LAST;
    case (state_q)
      IDLE: if (stb_i && !mio_i) begin
        state_d = ACC1;
        cnt_d   = '0;
        adr_d   = adr_i;
        dat_d   = dat_i;
        we_d    = we_i;
        byte_d  = byte_i;
        split_d = !byte_i && adr_i[0];
      end
      ACC1: begin
        state_d = last ? (split_q ? ACC2 : ACK) : ACC1;
        cnt_d   = last ? 3'd0 : cnt_q + 3'd1;
        lo_d    = last ? sram_dq_i[15:8] : lo_q;
      end
      ACC2: begin
        state_d = last ? ACK : ACC2;
        cnt_d   = last ? 3'd0 : cnt_q + 3'd1;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == ACK && !we_q)
      rdat_d = split_q ? {sram_dq_i[7:0], lo_q} :
               byte_q  ? {8'h00, adr_q[0] ? sram_dq_i[15:8] : sram_dq_i[7:0]} : sram_dq_i;
    // Strobes are decoded from the next state so the registered pins line up with the access
    acc     = state_d == ACC1 || state_d == ACC2;
    sec     = state_d == ACC2;
    whole   = !byte_d && !split_d;
    ack_d   = state_d == ACK;
    a_d     = acc ? adr_d[AW:1] + AW'(sec) : a_q;
    dq_d    = !acc ? dq_q : split_d ? (sec ? {8'h00, dat_d[15:8]} : {dat_d[7:0], 8'h00}) :
              byte_d ? {2{dat_d[7:0]}} : dat_d;
    dq_oe_d = acc && we_d;
    ce_n_d  = !acc;
    oe_n_d  = !(acc && !we_d);
    we_n_d  = !(acc && we_d && (WAIT == 0 || cnt_d != LAST));
    ub_n_d  = !(acc && (whole || (byte_d && adr_d[0]) || (split_d && !sec)));
    lb_n_d  = !(acc && (whole || (byte_d && !adr_d[0]) || (split_d && sec)));
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      we_q    <= 1'b0;
      byte_q  <= 1'b0;
      split_q <= 1'b0;
      lo_q    <= '0;
      rdat_q  <= '0;
      ack_q   <= 1'b0;
      a_q     <= '0;
      dq_q    <= '0;
      dq_oe_q <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      ub_n_q  <= 1'b1;
      lb_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      we_q    <= we_d;
      byte_q  <= byte_d;
      split_q <= split_d;
      lo_q    <= lo_d;
      rdat_q  <= rdat_d;
      ack_q   <= ack_d;
      a_q     <= a_d;
      dq_q    <= dq_d;
      dq_oe_q <= dq_oe_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      ub_n_q  <= ub_n_d;
      lb_n_q  <= lb_n_d;
    end
  end
  assign dat_o        = rdat_q;
  assign ack_o        = ack_q;
  assign sram_a_o     = a_q;
  assign sram_dq_o    = dq_q;
  assign sram_dq_oe_o = dq_oe_q;
  assign sram_ce_n_o  = ce_n_q;
  assign sram_oe_n_o  = oe_n_q;
  assign sram_we_n_o  = we_n_q;
  assign sram_ub_n_o  = ub_n_q;
  assign sram_lb_n_o  = lb_n_q;
endmodule

// File: tb/tb_zet_sram_bridge.sv
// tb_zet_sram_bridge: directed and randomized checks of the SRAM bridge against a
// byte-addressed memory model and an emulated word-wide SRAM.
module tb_zet_sram_bridge;
  localparam int WAIT = 1;
  localparam int AC   = WAIT + 1;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [19:0] adr = '0;
  logic [15:0] dat = '0, dat_o, sdq_i = '0, sdq_o;
  logic we = 1'b0, mio = 1'b0, byt = 1'b0, stb = 1'b0, ack;
  logic [18:0] sa;
  logic sdq_oe, ce_n, oe_n, we_n, ub_n, lb_n;
  int checks = 0, errors = 0;
  logic [15:0] sram [0:524287];
  logic [7:0]  rb [logic [19:0]];
  logic [15:0] last_rd = 16'h0000;
  logic        pl_en = 1'b0;
  logic [18:0] pl_w = '0;
  logic [15:0] pl_v = '0;
  logic [18:0] r_a [64];
  logic [15:0] r_dq [64];
  logic        r_ce [64], r_oe [64], r_we [64], r_ub [64], r_lb [64], r_dqoe [64];

  always #5 clk = ~clk;

  zet_sram_bridge #(.WAIT(WAIT), .AW(19)) dut (
    .clk_i(clk), .rst_ni(rst_n), .adr_i(adr), .dat_i(dat), .dat_o(dat_o), .we_i(we),
    .mio_i(mio), .byte_i(byt), .stb_i(stb), .ack_o(ack), .sram_a_o(sa), .sram_dq_i(sdq_i),
    .sram_dq_o(sdq_o), .sram_dq_oe_o(sdq_oe), .sram_ce_n_o(ce_n), .sram_oe_n_o(oe_n),
    .sram_we_n_o(we_n), .sram_ub_n_o(ub_n), .sram_lb_n_o(lb_n));

  // Emulated asynchronous SRAM: lane-masked writes while we_n is low, reads while oe_n is low
  always @(posedge clk) begin
    if (pl_en) sram[pl_w] <= pl_v;
    else if (!ce_n && !we_n && sdq_oe) begin
      if (!ub_n) sram[sa][15:8] <= sdq_o[15:8];
      if (!lb_n) sram[sa][7:0] <= sdq_o[7:0];
    end
  end
  always @(negedge clk) sdq_i <= (!ce_n && !oe_n) ? sram[sa] : 16'h0000;

  function automatic logic [7:0] get_b(input logic [19:0] x);
    return rb.exists(x) ? rb[x] : 8'h00;
  endfunction

  task automatic set_word(input logic [18:0] w, input logic [15:0] v);
    @(negedge clk);
    pl_w = w; pl_v = v; pl_en = 1'b1;
    rb[{w, 1'b0}] = v[7:0];
    rb[{w, 1'b1}] = v[15:8];
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic capture(input int k);
    r_a[k] = sa; r_dq[k] = sdq_o; r_ce[k] = ce_n; r_oe[k] = oe_n;
    r_we[k] = we_n; r_ub[k] = ub_n; r_lb[k] = lb_n; r_dqoe[k] = sdq_oe;
  endtask

  task automatic do_req(input logic [19:0] a, input logic [15:0] d, input logic w,
                        input logic b, output int lat);
    @(negedge clk);
    adr = a; dat = d; we = w; byt = b; mio = 1'b0; stb = 1'b1;
    @(posedge clk); #1;
    capture(0);
    lat = -1;
    for (int k = 1; k < 40 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (ack) lat = k; else capture(k);
    end
    stb = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ack, dat_o, sa, sdq_o, sdq_oe, ce_n, oe_n, we_n, ub_n, lb_n} !== {1'b0, 16'h0, 19'h0, 16'h0, 1'b0, 5'b11111})
      begin errors++; $display("FAIL reset_outputs got ack=%b dat=%h a=%h dq=%h oe=%b n=%b%b%b%b%b", ack, dat_o, sa, sdq_o, sdq_oe, ce_n, oe_n, we_n, ub_n, lb_n); end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_read_word();
    int lat;
    set_word(19'h00080, 16'hBEEF);
    do_req(20'h00100, 16'h0000, 1'b0, 1'b0, lat);
    checks++; if (lat !== AC) begin errors++; $display("FAIL rdw_latency got %0d exp %0d", lat, AC); end
    checks++; if ({r_ce[0], r_a[0], r_a[WAIT]} !== {1'b0, 19'h80, 19'h80}) begin errors++; $display("FAIL rdw_addr got ce=%b a=%h/%h exp 0 80", r_ce[0], r_a[0], r_a[WAIT]); end
    checks++; if ({r_ub[0], r_lb[0], r_oe[0], r_we[0], r_dqoe[0]} !== 5'b00010) begin errors++; $display("FAIL rdw_strobes got %b exp 00010", {r_ub[0], r_lb[0], r_oe[0], r_we[0], r_dqoe[0]}); end
    checks++; if (dat_o !== 16'hBEEF) begin errors++; $display("FAIL rdw_data got %h exp beef", dat_o); end
    last_rd = 16'hBEEF;
    @(posedge clk); #1;
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rdw_ack_width got %b exp 0", ack); end
  endtask

  task automatic test_byte_write();
    int lat;
    do_req(20'h000B7, 16'h005A, 1'b1, 1'b1, lat);
    checks++; if (lat !== AC) begin errors++; $display("FAIL bw_latency got %0d exp %0d", lat, AC); end
    checks++; if ({r_a[0], r_ub[0], r_lb[0], r_dq[0], r_dqoe[0]} !== {19'h5B, 2'b01, 16'h5A5A, 1'b1}) begin errors++; $display("FAIL bw_cycle got a=%h ub=%b lb=%b dq=%h oe=%b exp 5b 0 1 5a5a 1", r_a[0], r_ub[0], r_lb[0], r_dq[0], r_dqoe[0]); end
    checks++; if ({r_we[0], r_we[WAIT], r_oe[0]} !== {1'b0, WAIT == 0 ? 1'b0 : 1'b1, 1'b1}) begin errors++; $display("FAIL bw_we got we=%b%b oe=%b", r_we[0], r_we[WAIT], r_oe[0]); end
    checks++; if (sram[19'h5B][15:8] !== 8'h5A) begin errors++; $display("FAIL bw_mem got %h exp 5a", sram[19'h5B][15:8]); end
    checks++; if (dat_o !== last_rd) begin errors++; $display("FAIL bw_dat_hold got %h exp %h", dat_o, last_rd); end
  endtask

  task automatic test_split_read();
    int lat;
    set_word(19'h00100, 16'h12AB);
    set_word(19'h00101, 16'hCD34);
    do_req(20'h00201, 16'h0000, 1'b0, 1'b0, lat);
    checks++; if (lat !== 2 * AC) begin errors++; $display("FAIL sr_latency got %0d exp %0d", lat, 2 * AC); end
    checks++; if ({r_a[0], r_ub[0], r_lb[0]} !== {19'h100, 2'b01}) begin errors++; $display("FAIL sr_acc1 got a=%h ub=%b lb=%b", r_a[0], r_ub[0], r_lb[0]); end
    checks++; if ({r_a[AC], r_ub[AC], r_lb[AC], r_ce[AC]} !== {19'h101, 3'b100}) begin errors++; $display("FAIL sr_acc2 got a=%h ub=%b lb=%b ce=%b", r_a[AC], r_ub[AC], r_lb[AC], r_ce[AC]); end
    checks++; if (dat_o !== 16'h3412) begin errors++; $display("FAIL sr_data got %h exp 3412", dat_o); end
    last_rd = 16'h3412;
  endtask

  task automatic test_split_write_wrap();
    int lat;
    set_word(19'h7FFFF, 16'h1111);
    set_word(19'h00000, 16'h2222);
    do_req(20'hFFFFF, 16'hA1B2, 1'b1, 1'b0, lat);
    checks++; if (lat !== 2 * AC) begin errors++; $display("FAIL sw_latency got %0d exp %0d", lat, 2 * AC); end
    checks++; if ({r_a[0], r_dq[0], r_ub[0], r_lb[0]} !== {19'h7FFFF, 16'hB200, 2'b01}) begin errors++; $display("FAIL sw_acc1 got a=%h dq=%h ub=%b lb=%b", r_a[0], r_dq[0], r_ub[0], r_lb[0]); end
    checks++; if ({r_a[AC], r_dq[AC], r_ub[AC], r_lb[AC]} !== {19'h0, 16'h00A1, 2'b10}) begin errors++; $display("FAIL sw_acc2 got a=%h dq=%h ub=%b lb=%b", r_a[AC], r_dq[AC], r_ub[AC], r_lb[AC]); end
    checks++; if ({sram[19'h7FFFF], sram[19'h0]} !== {16'hB211, 16'h22A1}) begin errors++; $display("FAIL sw_mem got %h %h exp b211 22a1", sram[19'h7FFFF], sram[19'h0]); end
    checks++; if (dat_o !== last_rd) begin errors++; $display("FAIL sw_dat_hold got %h exp %h", dat_o, last_rd); end
  endtask

  task automatic test_io_stall();
    int bad = 0;
    @(negedge clk);
    adr = 20'h00100; we = 1'b0; byt = 1'b0; mio = 1'b1; stb = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (ack || !ce_n || !oe_n || !we_n || !ub_n || !lb_n) bad++;
    end
    stb = 1'b0; mio = 1'b0;
    checks++; if (bad !== 0) begin errors++; $display("FAIL io_stall got %0d active cycles exp 0", bad); end
  endtask

  task automatic test_stb_drop();
    int lat = -1, extra = 0;
    set_word(19'h00010, 16'h7E81);
    @(negedge clk);
    adr = 20'h00020; we = 1'b0; byt = 1'b0; mio = 1'b0; stb = 1'b1;
    @(posedge clk); #1;
    stb = 1'b0;
    for (int k = 1; k < 20 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (ack) lat = k;
    end
    checks++; if (lat !== AC) begin errors++; $display("FAIL drop_latency got %0d exp %0d", lat, AC); end
    checks++; if (dat_o !== 16'h7E81) begin errors++; $display("FAIL drop_data got %h exp 7e81", dat_o); end
    last_rd = 16'h7E81;
    repeat (5) begin @(posedge clk); #1; if (ack) extra++; end
    checks++; if (extra !== 0) begin errors++; $display("FAIL drop_extra_ack got %0d exp 0", extra); end
  endtask

  task automatic test_back_to_back();
    int lat, lat2 = -1;
    set_word(19'h00020, 16'h9C3D);
    set_word(19'h00021, 16'h47E6);
    do_req(20'h00040, 16'h0000, 1'b0, 1'b0, lat);
    checks++; if ({lat, dat_o} !== {AC, 16'h9C3D}) begin errors++; $display("FAIL b2b_first got lat=%0d dat=%h exp %0d 9c3d", lat, dat_o, AC); end
    adr = 20'h00043; byt = 1'b1; we = 1'b0; stb = 1'b1;
    for (int k = 1; k < 20 && lat2 < 0; k++) begin
      @(posedge clk); #1;
      if (ack) lat2 = k;
    end
    stb = 1'b0;
    checks++; if (lat2 !== AC + 2) begin errors++; $display("FAIL b2b_latency got %0d exp %0d", lat2, AC + 2); end
    checks++; if (dat_o !== 16'h0047) begin errors++; $display("FAIL b2b_data got %h exp 0047", dat_o); end
    last_rd = 16'h0047;
  endtask

  task automatic test_random();
    for (int w = 0; w < 64; w++) set_word(19'(w), 16'($urandom));
    for (int w = 0; w < 32; w++) set_word(19'h7FFE0 + 19'(w), 16'($urandom));
    for (int i = 0; i < 80; i++) begin
      logic [19:0] a, b1;
      logic [15:0] d;
      logic w, b;
      int lat, nacc;
      a = $urandom_range(0, 1) ? 20'($urandom_range(0, 126)) : 20'hFFFC0 + 20'($urandom_range(0, 63));
      d = 16'($urandom); w = 1'($urandom); b = 1'($urandom);
      b1 = a + 20'd1;
      nacc = (!b && a[0]) ? 2 : 1;
      do_req(a, d, w, b, lat);
      checks++; if (lat !== AC * nacc) begin errors++; $display("FAIL rnd_latency op%0d a=%h got %0d exp %0d", i, a, lat, AC * nacc); end
      if (lat == AC * nacc) for (int k = 0; k < lat; k++) begin
        logic [18:0] wd;
        logic eu, el, lst;
        wd  = a[19:1] + 19'(k / AC);
        eu  = (a[19:1] == wd && a[0]) || (!b && b1[19:1] == wd && b1[0]);
        el  = (a[19:1] == wd && !a[0]) || (!b && b1[19:1] == wd && !b1[0]);
        lst = (k % AC) == WAIT;
        checks++; if ({r_ce[k], r_a[k]} !== {1'b0, wd}) begin errors++; $display("FAIL rnd_addr op%0d c%0d got ce=%b a=%h exp 0 %h", i, k, r_ce[k], r_a[k], wd); end
        checks++; if ({r_ub[k], r_lb[k]} !== {!eu, !el}) begin errors++; $display("FAIL rnd_lanes op%0d c%0d got %b%b exp %b%b", i, k, r_ub[k], r_lb[k], !eu, !el); end
        checks++; if ({r_oe[k], r_we[k], r_dqoe[k]} !== {w, !(w && (WAIT == 0 || !lst)), w}) begin errors++; $display("FAIL rnd_strobes op%0d c%0d got %b%b%b", i, k, r_oe[k], r_we[k], r_dqoe[k]); end
        if (w && eu) begin
          checks++; if (r_dq[k][15:8] !== (a == {wd, 1'b1} ? d[7:0] : d[15:8])) begin errors++; $display("FAIL rnd_wdata_hi op%0d c%0d got %h", i, k, r_dq[k][15:8]); end
        end
        if (w && el) begin
          checks++; if (r_dq[k][7:0] !== (a == {wd, 1'b0} ? d[7:0] : d[15:8])) begin errors++; $display("FAIL rnd_wdata_lo op%0d c%0d got %h", i, k, r_dq[k][7:0]); end
        end
      end
      if (w) begin
        rb[a] = d[7:0];
        if (!b) rb[b1] = d[15:8];
      end else last_rd = b ? {8'h00, get_b(a)} : {get_b(b1), get_b(a)};
      checks++; if (dat_o !== last_rd) begin errors++; $display("FAIL rnd_dat op%0d a=%h we=%b byte=%b got %h exp %h", i, a, w, b, dat_o, last_rd); end
      @(posedge clk); #1;
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rnd_ack_width op%0d got %b exp 0", i, ack); end
    end
    for (int w = 0; w < 96; w++) begin
      logic [18:0] wa;
      wa = w < 64 ? 19'(w) : 19'h7FFE0 + 19'(w - 64);
      checks++; if (sram[wa] !== {get_b({wa, 1'b1}), get_b({wa, 1'b0})}) begin errors++; $display("FAIL rnd_mem word %h got %h exp %h", wa, sram[wa], {get_b({wa, 1'b1}), get_b({wa, 1'b0})}); end
    end
  endtask

  task automatic test_reset_mid();
    int lat, extra = 0;
    @(negedge clk);
    adr = 20'h00061; dat = 16'hF00D; we = 1'b1; byt = 1'b0; mio = 1'b0; stb = 1'b1;
    @(posedge clk);
    repeat (AC) @(posedge clk);
    #1;
    checks++; if ({ce_n, sa, ub_n, lb_n} !== {1'b0, 19'h31, 2'b10}) begin errors++; $display("FAIL rm_in_acc2 got ce=%b a=%h ub=%b lb=%b", ce_n, sa, ub_n, lb_n); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ack, dat_o, sa, sdq_o, sdq_oe, ce_n, oe_n, we_n, ub_n, lb_n} !== {1'b0, 16'h0, 19'h0, 16'h0, 1'b0, 5'b11111})
      begin errors++; $display("FAIL rm_async_reset got ack=%b dat=%h a=%h dq=%h oe=%b n=%b%b%b%b%b", ack, dat_o, sa, sdq_o, sdq_oe, ce_n, oe_n, we_n, ub_n, lb_n); end
    stb = 1'b0;
    last_rd = 16'h0000;
    @(negedge clk) rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; if (ack) extra++; end
    checks++; if (extra !== 0) begin errors++; $display("FAIL rm_stale_ack got %0d exp 0", extra); end
    do_req(20'h00020, 16'h0000, 1'b0, 1'b0, lat);
    checks++; if (lat !== AC) begin errors++; $display("FAIL rm_read_latency got %0d exp %0d", lat, AC); end
    checks++; if (dat_o !== {get_b(20'h00021), get_b(20'h00020)}) begin errors++; $display("FAIL rm_read_data got %h exp %h", dat_o, {get_b(20'h00021), get_b(20'h00020)}); end
  endtask

  initial begin
    test_reset();
    test_read_word();
    test_byte_write();
    test_split_read();
    test_split_write_wrap();
    test_io_stall();
    test_stb_drop();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/zet_sram_bridge.md
Name: zet_sram_bridge

Overview:
- Memory-side slave of the CPU bus. Consumes the CPU strobe/ack handshake and drives a 16-bit asynchronous SRAM.
- Replaces the free-running ack stub and behavioural memory with real wait-state-controlled SRAM cycles.
- Splits unaligned word accesses into two SRAM cycles. Ignores I/O cycles, which belong to a separate I/O decoder.

Parameters:
- WAIT, 1, extra clock cycles per SRAM access beyond the first. Each access lasts WAIT+1 cycles; legal range 0..7.
- AW, 19, SRAM word-address width. Byte address is AW+1 = 20 bits.

Ports:
- clk_i  in  1  system clock; all state changes on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- adr_i  in  20  CPU byte address.
- dat_i  in  16  CPU write data.
- dat_o  out  16  read data to CPU.
- we_i  in  1  1 = write.
- mio_i  in  1  1 = I/O cycle (ignored here), 0 = memory cycle.
- byte_i  in  1  1 = byte access, 0 = word access.
- stb_i  in  1  cycle request; held by the CPU until ack_o.
- ack_o  out  1  one-cycle completion pulse.
- sram_a_o  out  AW  SRAM word address.
- sram_dq_i  in  16  SRAM read data.
- sram_dq_o  out  16  SRAM write data.
- sram_dq_oe_o  out  1  1 = drive sram_dq_o onto the pads.
- sram_ce_n_o, sram_oe_n_o, sram_we_n_o  out  1 each  active-low SRAM strobes.
- sram_ub_n_o, sram_lb_n_o  out  1 each  active-low byte-lane enables. ub = bits 15:8 (odd byte); lb = bits 7:0 (even byte).

Behaviour:
- Reset (async, rst_ni=0):
  - State returns to IDLE immediately, including mid-access.
  - ack_o=0, dat_o=16'h0000, sram_a_o=0, sram_dq_o=0, sram_dq_oe_o=0.
  - All sram_*_n_o outputs =1.
- All outputs are registered.
- States:
  - IDLE: waiting for a request.
  - ACC1: first (or only) SRAM access.
  - ACC2: second access of an unaligned word.
  - ACK: ack_o=1 for exactly one cycle, then IDLE.
- Start condition: in IDLE, stb_i=1 and mio_i=0 sampled at edge E0.
  - Latch adr_i, dat_i, we_i and byte_i.
  - Enter ACC1; the split flag = (byte_i=0 and adr_i[0]=1).
- Access stall: stb_i=1 with mio_i=1 never starts an access, and ack_o stays 0.
- ACC1 and ACC2 each last exactly WAIT+1 cycles, counted by a 3-bit counter.
  - ACC1 exits to ACC2 if split, else to ACK.
  - ACC2 exits to ACK.
- ack_o rises at edge E0+(WAIT+1)*n, where n=1 for non-split and n=2 for split.
  - Aligned access with WAIT=1: ack_o high from edge E0+2 to edge E0+3.
- Strobes during an access: ce_n=0 for the whole access.
  - Read: oe_n=0, we_n=1, dq_oe=0.
  - Write: we_n=0 for all cycles except the last, oe_n=1, dq_oe=1 for the whole access. With WAIT=0, we_n=0 for the single cycle.
  - Between accesses (including the ACC1->ACC2 boundary): ce_n, oe_n, we_n and lane enables all =1 for at least 0 cycles. Outputs change only on edges, so no glitches.
- Addressing:
  - Access 1: sram_a_o = adr[19:1].
  - Access 2: sram_a_o = adr[19:1]+1, modulo 2^AW. The word at byte 0xFFFFF wraps to word 0.
- Lane enables:
  - Aligned word: ub=lb=0.
  - Byte access: lb=0 if adr[0]=0, else ub=0.
  - Split access 1: ub only. Split access 2: lb only.
- Write data:
  - Aligned word: dat_i.
  - Byte access: {dat_i[7:0],dat_i[7:0]}.
  - Split access 1: {dat_i[7:0],8'h00} with ub only.
  - Split access 2: {8'h00,dat_i[15:8]} with lb only.
- Read data: sram_dq_i is sampled on the last cycle of each access.
  - Aligned word: dat_o = the sampled word.
  - Byte access: dat_o = {8'h00, selected byte}.
  - Split access: dat_o[7:0] = access-1 bits 15:8; dat_o[15:8] = access-2 bits 7:0.
  - dat_o updates only when entering ACK and holds until the next read completes. Writes leave dat_o unchanged.
- Request lifetime:
  - stb_i falling before ack_o does not abort the access; the access completes and still pulses ack_o.
  - A new request is accepted no earlier than the edge after ACK, so back-to-back requests incur one IDLE-to-ACC1 sampling edge.

Test Plan:
- WAIT=1, read word at 0x00100 with SRAM word 0x80 = 16'hBEEF -> sram_a_o=0x00080, ub=lb=0, ack_o at E0+2 for 1 cycle, dat_o=16'hBEEF.
- WAIT=0, byte write 8'h5A to 0x00B7 -> one cycle, we_n=0, ub=0, lb=1, sram_dq_o=16'h5A5A, sram_a_o=0x5B, ack_o at E0+1.
- WAIT=1, unaligned word read at 0x00201 with words 0x100=16'h12AB and 0x101=16'hCD34 -> two accesses (ub then lb), ack_o at E0+4, dat_o=16'h3412.
- Unaligned word write 16'hA1B2 to 0xFFFFF -> access 1: sram_a_o=0x7FFFF, ub, data 16'hB200; access 2: sram_a_o=0x00000, lb, data 16'h00A1.
- stb_i=1 with mio_i=1 for 10 cycles -> no SRAM strobe asserted, ack_o stays 0.
- rst_ni pulled low during ACC2 of a split write -> all outputs at reset values immediately. After release, the next read completes normally with no stale ack_o.
